fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage -- instruction fetch stage with an IF/ID pipeline register.
//
// Issues one instruction-memory request at a time. The fetched word is placed
// in the IF/ID register, or parked in a one-entry hold buffer while decode is
// stalled and IF/ID is still occupied. Flush and redirect kill IF/ID, the hold
// buffer and any response still in flight.
//
// Ports
//   clk            in   1     rising-edge clock
//   reset          in   1     asynchronous, active-low reset
//   stall          in   1     decode cannot accept; IF/ID holds
//   flush          in   1     kill IF/ID contents and any in-flight fetch
//   redirect_valid in   1     load redirect_pc as the next fetch PC
//   redirect_pc    in   XLEN  branch/jump target (bits[1:0] ignored)
//   imem_req       out  1     fetch request valid
//   imem_addr      out  XLEN  fetch address, word aligned
//   imem_ready     in   1     memory accepts the request this cycle
//   imem_rvalid    in   1     instruction data valid
//   imem_rdata     in   32    fetched instruction
//   ifid_valid     out  1     IF/ID holds a live instruction
//   ifid_pc        out  XLEN  PC of the held instruction
//   ifid_instr     out  32    held instruction
//   ifid_pc_plus4  out  XLEN  ifid_pc + 4 (wraps)
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int               XLEN     = 64,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_pc,
  output logic [31:0]     ifid_instr,
  output logic [XLEN-1:0] ifid_pc_plus4
);

  localparam logic [31:0]     NOP_INSTR  = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic [31:0]     hold_instr_q, hold_instr_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;

  logic kill;
  logic advance;
  logic load_mem;
  logic load_hold;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    drop_d          = drop_q;
    ifid_valid_d    = ifid_valid_q;
    ifid_pc_d       = ifid_pc_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    hold_instr_d    = hold_instr_q;
    hold_pc_d       = hold_pc_q;
    imem_req        = 1'b0;
    advance         = 1'b0;
    load_mem        = 1'b0;
    load_hold       = 1'b0;
    kill            = flush | redirect_valid;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end

      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          state_d = WAIT;
          // The accepted request targets the old PC; its response is stale.
          if (kill) drop_d = 1'b1;
        end
      end

      WAIT: begin
        if (imem_rvalid) begin
          if (drop_q || kill) begin
            // Response belongs to a killed fetch: throw it away and refetch
            // from the (possibly redirected) PC without advancing.
            drop_d  = 1'b0;
            state_d = FETCH;
          end else if (!stall || !ifid_valid_q) begin
            load_mem = 1'b1;
            advance  = 1'b1;
            state_d  = FETCH;
          end else begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = pc_q;
            advance      = 1'b1;
            state_d      = HOLD;
          end
        end else if (kill) begin
          drop_d = 1'b1;
        end
      end

      HOLD: begin
        if (kill) begin
          state_d = FETCH;
        end else if (!stall) begin
          load_hold = 1'b1;
          state_d   = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase

    // Redirect wins over sequential advance.
    if (redirect_valid) begin
      pc_d = redirect_pc & ALIGN_MASK;
    end else if (advance) begin
      pc_d = pc_q + PC_STEP;
    end

    // IF/ID update. With stall low and nothing new arriving, decode has
    // consumed the entry, so a bubble is inserted rather than replaying it.
    if (kill) begin
      ifid_valid_d = 1'b0;
    end else if (load_mem) begin
      ifid_valid_d    = 1'b1;
      ifid_pc_d       = pc_q;
      ifid_instr_d    = imem_rdata;
      ifid_pc_plus4_d = pc_q + PC_STEP;
    end else if (load_hold) begin
      ifid_valid_d    = 1'b1;
      ifid_pc_d       = hold_pc_q;
      ifid_instr_d    = hold_instr_q;
      ifid_pc_plus4_d = hold_pc_q + PC_STEP;
    end else if (!stall) begin
      ifid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      pc_q            <= RESET_PC & ALIGN_MASK;
      drop_q          <= 1'b0;
      ifid_valid_q    <= 1'b0;
      ifid_pc_q       <= '0;
      ifid_instr_q    <= NOP_INSTR;
      ifid_pc_plus4_q <= '0;
      hold_instr_q    <= NOP_INSTR;
      hold_pc_q       <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      drop_q          <= drop_d;
      ifid_valid_q    <= ifid_valid_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      hold_instr_q    <= hold_instr_d;
      hold_pc_q       <= hold_pc_d;
    end
  end

  assign imem_addr     = pc_q & ALIGN_MASK;
  assign ifid_valid    = ifid_valid_q;
  assign ifid_pc       = ifid_pc_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;

endmodule
